sha2_round_state: RTL and testbench

//  Sequential SHA-2 working-variable engine, parametrised for SHA-256 (32b) or SHA-512 (64b).

---
 rtl/sha2_pkg.sv | 37 +++
 rtl/sha2_var_rotate.sv | 33 +++
 rtl/sha2_round_state.sv | 142 ++++++++++++++
 tb/tb_sha2_round_state.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 round-state engine.
//   rstate_e      : block-level FSM state encoding
//   SHA256_* /
//   SHA512_*      : word widths, round counts and initial hash values
//   rounds_for()  : round count matching a given word width
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } rstate_e;

  localparam int SHA256_W      = 32;
  localparam int SHA512_W      = 64;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;

  // H0 in the MSBs, H7 in the LSBs, matching the init_hash port layout.
  localparam logic [8*SHA256_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [8*SHA512_W-1:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  function automatic int rounds_for(input int word_w);
    return (word_w == SHA256_W) ? SHA256_ROUNDS : SHA512_ROUNDS;
  endfunction

endpackage

// File: rtl/sha2_var_rotate.sv
// One SHA-2 round applied to the working variables (purely combinational).
//   vars     : current {a,b,c,d,e,f,g,h}, a in the MSBs
//   t1, t2   : round terms from the T1/T2 datapath
//   vars_nxt : {a..h} after the round; sums wrap modulo 2^WORD_W
module sha2_var_rotate #(
  parameter int WORD_W = 64
) (
  input  logic [8*WORD_W-1:0] vars,
  input  logic [WORD_W-1:0]   t1,
  input  logic [WORD_W-1:0]   t2,
  output logic [8*WORD_W-1:0] vars_nxt
);

  // Word 7 is a, word 0 is h.
  logic [7:0][WORD_W-1:0] v;
  logic [7:0][WORD_W-1:0] n;

  assign v = vars;

  always_comb begin
    n[7] = t1 + t2;     // a
    n[6] = v[7];        // b <= a
    n[5] = v[6];        // c <= b
    n[4] = v[5];        // d <= c
    n[3] = v[4] + t1;   // e <= d + T1
    n[2] = v[3];        // f <= e
    n[1] = v[2];        // g <= f
    n[0] = v[1];        // h <= g
  end

  assign vars_nxt = n;

endmodule

// File: rtl/sha2_round_state.sv
// SHA-2 working-variable engine (SHA-256 with WORD_W=32/ROUNDS=64,
// SHA-512 with WORD_W=64/ROUNDS=80).
// Holds a..h and the chaining hash H0..H7, applies one round per accepted
// (T1,T2) beat, then does the feed-forward add and offers the digest.
//
// Optional build macro: SHA2_RSTATE_DBG_EN adds output round_idx (= round
// counter); without it the port does not exist.
//
// Ports
//   clk, rst_n                 clock / async active-low reset
//   start, load_iv, init_hash  block start (IDLE only); load IV or chain H
//   init_ready                 high in IDLE
//   abort                      cancel to IDLE from any state, H and a..h kept
//   rnd_valid/t1/t2/ready      round beat handshake (ready in ROUND)
//   state_out                  current {a..h}, feeds the T1/T2 datapath
//   digest, digest_valid/ready digest handshake (valid in DONE)
//   busy                       state != IDLE
module sha2_round_state
  import sha2_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int ROUNDS = 80,
  localparam int CNT_W = $clog2(ROUNDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                load_iv,
  input  logic [8*WORD_W-1:0] init_hash,
  output logic                init_ready,
  input  logic                abort,
  input  logic                rnd_valid,
  input  logic [WORD_W-1:0]   rnd_t1,
  input  logic [WORD_W-1:0]   rnd_t2,
  output logic                rnd_ready,
  output logic [8*WORD_W-1:0] state_out,
  output logic [8*WORD_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
`ifdef SHA2_RSTATE_DBG_EN
  output logic [CNT_W-1:0]    round_idx,
`endif
  output logic                busy
);

  rstate_e                state;
  rstate_e                state_nxt;
  logic [7:0][WORD_W-1:0] hash;      // H0 in word 7
  logic [7:0][WORD_W-1:0] vars;      // a in word 7
  logic [7:0][WORD_W-1:0] hash_ff;   // H + a..h, feed-forward result
  logic [8*WORD_W-1:0]    vars_rot;
  logic [8*WORD_W-1:0]    blk_iv;
  logic [CNT_W-1:0]       cnt;
  logic                   beat;
  logic                   last_beat;

  assign beat      = rnd_valid && (state == ROUND);
  assign last_beat = beat && (cnt == CNT_W'(ROUNDS - 1));

  // Chaining simply re-uses the held H as the starting value.
  assign blk_iv = load_iv ? init_hash : hash;

  sha2_var_rotate #(
    .WORD_W (WORD_W)
  ) u_rotate (
    .vars     (vars),
    .t1       (rnd_t1),
    .t2       (rnd_t2),
    .vars_nxt (vars_rot)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_ff
    assign hash_ff[gi] = hash[gi] + vars[gi];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)        state_nxt = ROUND;
        ROUND:   if (last_beat)    state_nxt = FINAL;
        FINAL:                     state_nxt = DONE;
        DONE:    if (digest_ready) state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    init_ready   = (state == IDLE);
    rnd_ready    = (state == ROUND);
    digest_valid = (state == DONE);
    busy         = (state != IDLE);
  end

  // ----------------------------------------------------------- datapath
  // abort only clears the round counter; H and a..h stay as they were so
  // the caller can inspect or chain from them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash <= '0;
      vars <= '0;
      cnt  <= '0;
    end else if (abort) begin
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            hash <= blk_iv;
            vars <= blk_iv;
            cnt  <= '0;
          end
        end
        ROUND: begin
          if (beat) begin
            vars <= vars_rot;
            cnt  <= cnt + CNT_W'(1);
          end
        end
        FINAL:   hash <= hash_ff;
        default: ;
      endcase
    end
  end

  assign state_out = vars;
  assign digest    = hash;

`ifdef SHA2_RSTATE_DBG_EN
  assign round_idx = cnt;
`endif

endmodule

// File: tb/tb_sha2_round_state.sv
// Self-checking bench: a SHA-256 instance and a SHA-512 instance driven from
// shared stimulus, compared against a word-list model of the SHA-2 state
// update and against published digests.
module tb_sha2_round_state;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start32, start64, load_iv, abort, rnd_valid, digest_ready;
  logic [511:0] init_hash;
  logic [63:0]  t1, t2;

  logic         ir32, rr32, dv32, busy32;
  logic [255:0] so32, dg32;
  logic         ir64, rr64, dv64, busy64;
  logic [511:0] so64, dg64;
`ifdef SHA2_RSTATE_DBG_EN
  logic [5:0]   ri32;
  logic [6:0]   ri64;
`endif

  always #5 clk = ~clk;

  sha2_round_state #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .load_iv(load_iv),
    .init_hash(init_hash[255:0]), .init_ready(ir32), .abort(abort),
    .rnd_valid(rnd_valid), .rnd_t1(t1[31:0]), .rnd_t2(t2[31:0]),
    .rnd_ready(rr32), .state_out(so32), .digest(dg32),
    .digest_valid(dv32), .digest_ready(digest_ready),
`ifdef SHA2_RSTATE_DBG_EN
    .round_idx(ri32),
`endif
    .busy(busy32)
  );

  sha2_round_state #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .load_iv(load_iv),
    .init_hash(init_hash), .init_ready(ir64), .abort(abort),
    .rnd_valid(rnd_valid), .rnd_t1(t1), .rnd_t2(t2),
    .rnd_ready(rr64), .state_out(so64), .digest(dg64),
    .digest_valid(dv64), .digest_ready(digest_ready),
`ifdef SHA2_RSTATE_DBG_EN
    .round_idx(ri64),
`endif
    .busy(busy64)
  );

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] ABC512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------- model
  // Index 0 = a / H0 ... index 7 = h / H7. Words kept in 64 bits, masked to
  // 32 for the SHA-256 instance.
  logic [63:0] mh [8];
  logic [63:0] mv [8];
  logic [63:0] ws [80];
  logic [63:0] blk_msg [16];

  function automatic logic [63:0] m(input bit w, input logic [63:0] x);
    return w ? x : (x & 64'hFFFF_FFFF);
  endfunction

  function automatic logic [63:0] rotr(input bit w, input logic [63:0] x, input int n);
    logic [31:0] y;
    y = x[31:0];
    if (w) return (x >> n) | (x << (64 - n));
    return {32'b0, (y >> n) | (y << (32 - n))};
  endfunction

  function automatic logic [63:0] bsig0(input bit w, input logic [63:0] x);
    return w ? rotr(1, x, 28) ^ rotr(1, x, 34) ^ rotr(1, x, 39)
             : rotr(0, x, 2) ^ rotr(0, x, 13) ^ rotr(0, x, 22);
  endfunction
  function automatic logic [63:0] bsig1(input bit w, input logic [63:0] x);
    return w ? rotr(1, x, 14) ^ rotr(1, x, 18) ^ rotr(1, x, 41)
             : rotr(0, x, 6) ^ rotr(0, x, 11) ^ rotr(0, x, 25);
  endfunction
  function automatic logic [63:0] ssig0(input bit w, input logic [63:0] x);
    return w ? rotr(1, x, 1) ^ rotr(1, x, 8) ^ (x >> 7)
             : rotr(0, x, 7) ^ rotr(0, x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [63:0] ssig1(input bit w, input logic [63:0] x);
    return w ? rotr(1, x, 19) ^ rotr(1, x, 61) ^ (x >> 6)
             : rotr(0, x, 17) ^ rotr(0, x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] pk(input bit w, input bit sel_h);
    logic [511:0] r;
    logic [63:0]  x;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      x = sel_h ? mh[i] : mv[i];
      r = w ? {r[447:0], x} : {r[479:0], x[31:0]};
    end
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom)};
    return r;
  endfunction

  task automatic model_start(input bit w, input bit load, input logic [511:0] iv);
    for (int i = 0; i < 8; i++) begin
      if (load) mh[i] = w ? iv[64*(7-i) +: 64] : {32'b0, iv[32*(7-i) +: 32]};
      mv[i] = mh[i];
    end
  endtask

  task automatic model_round(input bit w, input logic [63:0] a1, input logic [63:0] a2);
    for (int i = 7; i > 0; i--) mv[i] = mv[i-1];
    mv[4] = m(w, mv[4] + a1);
    mv[0] = m(w, a1 + a2);
  endtask

  task automatic model_final(input bit w);
    for (int i = 0; i < 8; i++) mh[i] = m(w, mh[i] + mv[i]);
  endtask

  task automatic sched(input bit w);
    for (int t = 0; t < 80; t++)
      ws[t] = (t < 16) ? m(w, blk_msg[t])
            : m(w, ssig1(w, ws[t-2]) + ws[t-7] + ssig0(w, ws[t-15]) + ws[t-16]);
  endtask

  task automatic sha_tt(input bit w, input int t, output logic [63:0] a1, output logic [63:0] a2);
    logic [63:0] ch, maj, k;
    ch  = m(w, (mv[4] & mv[5]) ^ (~mv[4] & mv[6]));
    maj = (mv[0] & mv[1]) ^ (mv[0] & mv[2]) ^ (mv[1] & mv[2]);
    k   = w ? K512[t] : {32'b0, K256[t]};
    a1  = m(w, mv[7] + bsig1(w, mv[4]) + ch + k + ws[t]);
    a2  = m(w, bsig0(w, mv[0]) + maj);
  endtask

  // --------------------------------------------------------- observers
  function automatic logic [511:0] o_dig(input bit w); return w ? dg64 : {256'b0, dg32}; endfunction
  function automatic logic [511:0] o_so(input bit w);  return w ? so64 : {256'b0, so32}; endfunction
  function automatic logic o_dv(input bit w);   return w ? dv64 : dv32; endfunction
  function automatic logic o_ir(input bit w);   return w ? ir64 : ir32; endfunction
  function automatic logic o_busy(input bit w); return w ? busy64 : busy32; endfunction
  function automatic logic o_rr(input bit w);   return w ? rr64 : rr32; endfunction

  // ---------------------------------------------------------- stimulus
  // All tasks start and end just after a falling edge.
  task automatic start_blk(input bit w, input bit load, input logic [511:0] iv);
    init_hash = iv;
    load_iv   = load;
    if (w) start64 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    model_start(w, load, iv);
    chk("start_busy", o_busy(w), 1'b1);
    chk("start_vars", o_so(w), pk(w, 1'b0));
  endtask

  task automatic beat(input bit w, input logic [63:0] a1, input logic [63:0] a2, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    rnd_valid = 1'b0;
    repeat (g) @(negedge clk);
    chk("rnd_ready", o_rr(w), 1'b1);
    rnd_valid = 1'b1;
    t1 = a1;
    t2 = a2;
    @(negedge clk);
    rnd_valid = 1'b0;
    model_round(w, a1, a2);
  endtask

  // mode 0: T1=T2=0, 1: random, 2: real SHA terms from the schedule
  task automatic run_beats(input bit w, input int mode, input int nb, input int maxgap);
    logic [63:0] a1, a2;
    for (int t = 0; t < nb; t++) begin
      case (mode)
        0:       begin a1 = '0; a2 = '0; end
        1:       begin a1 = m(w, {$urandom, $urandom}); a2 = m(w, {$urandom, $urandom}); end
        default: sha_tt(w, t, a1, a2);
      endcase
      beat(w, a1, a2, maxgap);
    end
  endtask

  // Last handshake edge moves to FINAL; the next edge moves to DONE.
  task automatic finish_blk(input bit w, input string tag);
    chk("lat_final_dv", o_dv(w), 1'b0);
    @(negedge clk);
    chk("lat_done_dv", o_dv(w), 1'b1);
    model_final(w);
    chk(tag, o_dig(w), pk(w, 1'b1));
  endtask

  task automatic release_blk(input bit w);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("back_idle", o_ir(w), 1'b1);
    chk("back_idle_dv", o_dv(w), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start32 = 1'b0; start64 = 1'b0; load_iv = 1'b0; abort = 1'b0;
    rnd_valid = 1'b0; digest_ready = 1'b0; init_hash = '0; t1 = '0; t2 = '0;
    for (int i = 0; i < 8; i++) begin mh[i] = '0; mv[i] = '0; end
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_init_ready", o_ir(w[0]), 1'b1);
      chk("rst_dv", o_dv(w[0]), 1'b0);
      chk("rst_busy", o_busy(w[0]), 1'b0);
      chk("rst_rnd_ready", o_rr(w[0]), 1'b0);
      chk("rst_digest", o_dig(w[0]), '0);
      chk("rst_state", o_so(w[0]), '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero rounds: a..h drain to zero, so the digest is the IV itself.
    start_blk(0, 1, {256'b0, IV256});
    run_beats(0, 0, 64, 0);
    finish_blk(0, "zero_dig_model");
    chk("zero_dig_iv", o_dig(0), {256'b0, IV256});
    release_blk(0);

    // Reset in the middle of ROUND drops everything.
    start_blk(0, 1, {256'b0, IV256});
    run_beats(0, 1, 10, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_init_ready", ir32, 1'b1);
    chk("midrst_dv", dv32, 1'b0);
    chk("midrst_digest", o_dig(0), '0);
    chk("midrst_state", o_so(0), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin mh[i] = '0; mv[i] = '0; end
    @(negedge clk);

    // Wrap on the first round: a = FFFFFFFF+1 = 0, e = d - 1.
    start_blk(0, 1, {256'b0, IV256});
    beat(0, 64'hFFFF_FFFF, 64'h1, 0);
    chk("wrap_vars", o_so(0),
        {256'b0, 256'h00000000_6a09e667_bb67ae85_3c6ef372_a54ff539_510e527f_9b05688c_1f83d9ab});
    chk("wrap_vars_model", o_so(0), pk(0, 1'b0));
    run_beats(0, 1, 63, 1);
    finish_blk(0, "wrap_dig");
    release_blk(0);

    // SHA-256("abc")
    for (int i = 0; i < 16; i++) blk_msg[i] = '0;
    blk_msg[0] = 64'h61626380;
    blk_msg[15] = 64'h18;
    sched(0);
    start_blk(0, 1, {256'b0, IV256});
    run_beats(0, 2, 64, 1);
    finish_blk(0, "abc256_model");
    chk("abc256_const", o_dig(0), {256'b0, ABC256});

    // Stall DONE with a stray start: digest holds, no restart.
    for (int k = 0; k < 5; k++) begin
      start32 = (k == 2);
      @(negedge clk);
      chk("hold_dv", dv32, 1'b1);
      chk("hold_digest", o_dig(0), pk(0, 1'b1));
    end
    start32 = 1'b0;
    release_blk(0);

    // Second block chained from the abc digest (init_hash is noise).
    for (int i = 0; i < 16; i++) blk_msg[i] = {32'b0, $urandom};
    sched(0);
    start_blk(0, 0, rnd512());
    run_beats(0, 2, 64, 0);
    finish_blk(0, "chain_dig");
    release_blk(0);

    // Abort after 30 beats, with a beat offered on the same edge.
    for (int i = 0; i < 16; i++) blk_msg[i] = {32'b0, $urandom};
    sched(0);
    start_blk(0, 1, {256'b0, IV256});
    run_beats(0, 2, 30, 3);
    abort = 1'b1; rnd_valid = 1'b1; t1 = {$urandom, $urandom};
    @(negedge clk);
    abort = 1'b0; rnd_valid = 1'b0;
    chk("abort_idle", ir32, 1'b1);
    chk("abort_busy", busy32, 1'b0);
    chk("abort_h_kept", o_dig(0), pk(0, 1'b1));
    chk("abort_vars_kept", o_so(0), pk(0, 1'b0));
    start_blk(0, 0, rnd512());
    run_beats(0, 1, 64, 3);
    finish_blk(0, "post_abort_dig");
    release_blk(0);

    // SHA-512("abc")
    for (int i = 0; i < 16; i++) blk_msg[i] = '0;
    blk_msg[0] = 64'h6162638000000000;
    blk_msg[15] = 64'h18;
    sched(1);
    start_blk(1, 1, IV512);
    run_beats(1, 2, 80, 1);
    finish_blk(1, "abc512_model");
    chk("abc512_const", o_dig(1), ABC512);

    // Abort in DONE drops the digest handshake, H stays.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_dv", dv64, 1'b0);
    chk("abort_done_idle", ir64, 1'b1);
    chk("abort_done_h", o_dig(1), pk(1, 1'b1));

    // abort beats start in IDLE.
    start64 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start64 = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy64, 1'b0);

    // Random chained SHA-512 block with valid gaps.
    start_blk(1, 0, rnd512());
    run_beats(1, 1, 80, 2);
    finish_blk(1, "rand512_dig");
    release_blk(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
